// File: rtl/ps2_kb_pkg.sv
// Shared constants and types for the PS/2 set-2 scan-code controller.
package ps2_kb_pkg;

   localparam logic [7:0] SC_EXT  = 8'hE0;
   localparam logic [7:0] SC_BRK  = 8'hF0;
   localparam logic [7:0] SC_ERR0 = 8'h00;
   localparam logic [7:0] SC_ERR1 = 8'hFF;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_GOT_E0   = 2'd1,
      ST_GOT_F0   = 2'd2,
      ST_GOT_E0F0 = 2'd3
   } kb_state_e;

   // Event word layout: {ext, brk, code[7:0]}
   localparam int EV_W        = 10;
   localparam int EV_EXT_BIT  = 9;
   localparam int EV_BRK_BIT  = 8;
   localparam int EV_CODE_LSB = 0;

   function automatic logic [EV_W-1:0] make_event(input logic ext,
                                                  input logic brk,
                                                  input logic [7:0] code);
      return {ext, brk, code};
   endfunction

endpackage

// File: rtl/ps2_kb_fifo.sv
// Generic first-word-fall-through FIFO; head entry is visible on rd_data while not empty.
module ps2_kb_fifo #(
   parameter int DATA_W = 10,
   parameter int ADDR_W = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd,
   output logic [DATA_W-1:0] rd_data,
   output logic              full,
   output logic              empty
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
   logic              rd_ok, wr_ok;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                  (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);

   assign rd_ok   = rd && !empty;
   assign wr_ok   = wr && (!full || rd_ok);
   assign rd_data = empty ? '0 : mem_q[rd_ptr_q[ADDR_W-1:0]];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (wr_ok) begin
         mem_d[wr_ptr_q[ADDR_W-1:0]] = wr_data;
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (rd_ok) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         mem_q    <= mem_d;
      end
   end

endmodule

// File: rtl/ps2_kb_ctrl.sv
// Assembles PS/2 set-2 byte sequences into key events, supervises inter-byte timing, queues events.
//   state       | meaning
//   ST_IDLE     | no partial sequence pending
//   ST_GOT_E0   | extended prefix seen
//   ST_GOT_F0   | break prefix seen
//   ST_GOT_E0F0 | extended break prefix seen
module ps2_kb_ctrl
   import ps2_kb_pkg::*;
#(
   parameter int ADDR_W         = 2,
   parameter int TIMEOUT_CYCLES = 2_000_000,
   parameter int TO_W           = 21
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx_done_tick,
   input  logic [7:0] rx_data,
   output logic       rx_en,
   output logic       key_valid,
   output logic [7:0] key_code,
   output logic       key_ext,
   output logic       key_break,
   input  logic       key_rd,
   output logic       err_tick,
   output logic       overflow,
   input  logic       clr_ovf
);

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   kb_state_e        state_q, state_d;
   logic [TO_W-1:0]  to_q, to_d;
   logic             ovf_q, ovf_d;
   logic             push;
   logic [EV_W-1:0]  push_ev;
   logic [EV_W-1:0]  head_ev;
   logic             fifo_full, fifo_empty;
   logic             is_err_byte, is_prefix;

   assign is_err_byte = (rx_data == SC_ERR0) || (rx_data == SC_ERR1);
   assign is_prefix   = (rx_data == SC_EXT) || (rx_data == SC_BRK);

   always_comb begin
      state_d  = state_q;
      to_d     = to_q;
      push     = 1'b0;
      push_ev  = '0;
      err_tick = 1'b0;
      if (rx_done_tick) begin
         to_d = '0;
         if (is_err_byte) begin
            state_d  = ST_IDLE;
            err_tick = 1'b1;
         end else begin
            unique case (state_q)
               ST_IDLE: begin
                  if (rx_data == SC_EXT)      state_d = ST_GOT_E0;
                  else if (rx_data == SC_BRK) state_d = ST_GOT_F0;
                  else begin
                     push    = 1'b1;
                     push_ev = make_event(1'b0, 1'b0, rx_data);
                  end
               end
               ST_GOT_E0: begin
                  if (rx_data == SC_BRK)      state_d = ST_GOT_E0F0;
                  else if (rx_data == SC_EXT) state_d = ST_GOT_E0;
                  else begin
                     push    = 1'b1;
                     push_ev = make_event(1'b1, 1'b0, rx_data);
                     state_d = ST_IDLE;
                  end
               end
               ST_GOT_F0, ST_GOT_E0F0: begin
                  state_d = ST_IDLE;
                  if (is_prefix) begin
                     err_tick = 1'b1;
                  end else begin
                     push    = 1'b1;
                     push_ev = make_event(state_q == ST_GOT_E0F0, 1'b1, rx_data);
                  end
               end
               default: state_d = ST_IDLE;
            endcase
         end
      end else if (state_q != ST_IDLE) begin
         if (to_q == TO_LAST) begin
            state_d  = ST_IDLE;
            err_tick = 1'b1;
            to_d     = '0;
         end else begin
            to_d = to_q + 1'b1;
         end
      end else begin
         to_d = '0;
      end
   end

   // A pop in the same cycle frees the slot, so only a push without pop is dropped.
   always_comb begin
      ovf_d = ovf_q;
      if (push && fifo_full && !key_rd) ovf_d = 1'b1;
      else if (clr_ovf)                 ovf_d = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         to_q    <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         to_q    <= to_d;
         ovf_q   <= ovf_d;
      end
   end

   ps2_kb_fifo #(
      .DATA_W (EV_W),
      .ADDR_W (ADDR_W)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr      (push),
      .wr_data (push_ev),
      .rd      (key_rd),
      .rd_data (head_ev),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign rx_en     = ~fifo_full;
   assign key_valid = ~fifo_empty;
   assign key_code  = head_ev[EV_CODE_LSB +: 8];
   assign key_ext   = head_ev[EV_EXT_BIT];
   assign key_break = head_ev[EV_BRK_BIT];
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_ps2_kb_ctrl.sv
// Directed bench for ps2_kb_ctrl with a short timeout so stall handling is reachable.
module tb_ps2_kb_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       rx_done_tick;
   logic [7:0] rx_data;
   logic       rx_en;
   logic       key_valid;
   logic [7:0] key_code;
   logic       key_ext;
   logic       key_break;
   logic       key_rd;
   logic       err_tick;
   logic       overflow;
   logic       clr_ovf;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   ps2_kb_ctrl #(
      .ADDR_W         (2),
      .TIMEOUT_CYCLES (100),
      .TO_W           (21)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .rx_done_tick (rx_done_tick),
      .rx_data      (rx_data),
      .rx_en        (rx_en),
      .key_valid    (key_valid),
      .key_code     (key_code),
      .key_ext      (key_ext),
      .key_break    (key_break),
      .key_rd       (key_rd),
      .err_tick     (err_tick),
      .overflow     (overflow),
      .clr_ovf      (clr_ovf)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp)
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      else
         n_pass++;
   endtask

   // Drives one receiver strobe; err_tick is sampled mid-cycle while the strobe is high.
   task automatic send_byte(input logic [7:0] b, output logic err_seen);
      @(negedge clk);
      rx_data      = b;
      rx_done_tick = 1'b1;
      #2 err_seen = err_tick;
      @(negedge clk);
      rx_done_tick = 1'b0;
   endtask

   task automatic pop();
      @(negedge clk);
      key_rd = 1'b1;
      @(negedge clk);
      key_rd = 1'b0;
   endtask

   function automatic logic [31:0] head();
      return {21'd0, key_valid, key_ext, key_break, key_code};
   endfunction

   function automatic logic [31:0] ev(input logic ext, input logic brk, input logic [7:0] c);
      return {21'd0, 1'b1, ext, brk, c};
   endfunction

   logic e;
   int   n;
   logic [7:0] fill_codes [4];

   initial begin
      reset = 1'b1; rx_done_tick = 1'b0; rx_data = 8'h00; key_rd = 1'b0; clr_ovf = 1'b0;
      fill_codes[0] = 8'h16; fill_codes[1] = 8'h1E; fill_codes[2] = 8'h26; fill_codes[3] = 8'h25;
      repeat (3) @(negedge clk);
      chk("rst_head", head(), 32'd0);
      chk("rst_rx_en", {31'd0, rx_en}, 32'd1);
      chk("rst_ovf", {31'd0, overflow}, 32'd0);
      chk("rst_err", {31'd0, err_tick}, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // plain make
      send_byte(8'h1C, e);
      chk("make_err", {31'd0, e}, 32'd0);
      chk("make_ev", head(), ev(1'b0, 1'b0, 8'h1C));
      pop();
      chk("make_pop", {31'd0, key_valid}, 32'd0);

      // break
      send_byte(8'hF0, e);
      chk("brk_pre", {31'd0, key_valid}, 32'd0);
      send_byte(8'h1C, e);
      chk("brk_ev", head(), ev(1'b0, 1'b1, 8'h1C));
      pop();
      chk("brk_one", {31'd0, key_valid}, 32'd0);

      // extended break
      send_byte(8'hE0, e);
      send_byte(8'hF0, e);
      send_byte(8'h75, e);
      chk("xbrk_ev", head(), ev(1'b1, 1'b1, 8'h75));
      pop();
      chk("xbrk_one", {31'd0, key_valid}, 32'd0);

      // repeated E0 is tolerated
      send_byte(8'hE0, e);
      send_byte(8'hE0, e);
      chk("e0e0_err", {31'd0, e}, 32'd0);
      send_byte(8'h74, e);
      chk("e0e0_ev", head(), ev(1'b1, 1'b0, 8'h74));
      pop();

      // F0 F0 protocol error
      send_byte(8'hF0, e);
      send_byte(8'hF0, e);
      chk("f0f0_err", {31'd0, e}, 32'd1);
      chk("f0f0_noev", {31'd0, key_valid}, 32'd0);
      send_byte(8'h29, e);
      chk("f0f0_next", head(), ev(1'b0, 1'b0, 8'h29));
      pop();

      // keyboard error byte mid-sequence
      send_byte(8'hE0, e);
      send_byte(8'hFF, e);
      chk("ff_err", {31'd0, e}, 32'd1);
      chk("ff_noev", {31'd0, key_valid}, 32'd0);

      // timeout: counter 0..99 in GOT_E0, error on its 100th cycle there
      send_byte(8'hE0, e);
      n = 1;
      while (!err_tick && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("to_cycle", n, 32'd100);
      @(negedge clk);
      chk("to_pulse", {31'd0, err_tick}, 32'd0);
      send_byte(8'h6B, e);
      chk("to_next", head(), ev(1'b0, 1'b0, 8'h6B));
      pop();

      // late byte on the final allowed cycle still counts
      send_byte(8'hE0, e);
      repeat (98) @(negedge clk);
      send_byte(8'h6B, e);
      chk("to_race_err", {31'd0, e}, 32'd0);
      chk("to_race_ev", head(), ev(1'b1, 1'b0, 8'h6B));
      pop();

      // FIFO full and overflow
      for (int i = 0; i < 4; i++) send_byte(fill_codes[i], e);
      chk("full_rx_en", {31'd0, rx_en}, 32'd0);
      send_byte(8'h2E, e);
      chk("ovf_set", {31'd0, overflow}, 32'd1);
      for (int i = 0; i < 4; i++) begin
         chk("full_order", head(), ev(1'b0, 1'b0, fill_codes[i]));
         pop();
      end
      chk("drain_empty", {31'd0, key_valid}, 32'd0);
      chk("drain_rx_en", {31'd0, rx_en}, 32'd1);
      chk("ovf_sticky", {31'd0, overflow}, 32'd1);
      @(negedge clk); clr_ovf = 1'b1;
      @(negedge clk); clr_ovf = 1'b0;
      chk("ovf_clr", {31'd0, overflow}, 32'd0);

      // async reset with a partial sequence and queued events
      send_byte(8'h1C, e);
      send_byte(8'h2C, e);
      send_byte(8'hE0, e);
      send_byte(8'hF0, e);
      #1 reset = 1'b1;
      #2;
      chk("arst_valid", {31'd0, key_valid}, 32'd0);
      chk("arst_rx_en", {31'd0, rx_en}, 32'd1);
      @(negedge clk);
      reset = 1'b0;
      send_byte(8'h1C, e);
      chk("arst_next", head(), ev(1'b0, 1'b0, 8'h1C));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/ps2_kb_ctrl.md
Name: ps2_kb_ctrl

Overview:
- Scan-code controller that sits directly after the PS/2 receiver.
- Gates the receiver's enable and consumes received bytes.
- Assembles multi-byte set-2 sequences (E0 extended prefix, F0 break prefix) into single key events and buffers them in a small first-word-fall-through FIFO for the game/control logic.
- Supervises inter-byte timing: a stalled partial sequence is aborted.

Parameters:
- ADDR_W, 2, log2 of event FIFO depth (depth = 4).
- TIMEOUT_CYCLES, 2_000_000, max clk cycles allowed between bytes of one sequence (20 ms at 100 MHz).
- TO_W, 21, timeout counter width; must hold TIMEOUT_CYCLES-1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- rx_done_tick  in  1  one-cycle strobe from receiver: rx_data valid.
- rx_data  in  8  received byte.
- rx_en  out  1  receiver enable; = ~fifo_full.
- key_valid  out  1  FIFO not empty; head event on key_code/key_ext/key_break.
- key_code  out  8  scan code of head event.
- key_ext  out  1  head event had E0 prefix.
- key_break  out  1  head event is a release (F0 prefix).
- key_rd  in  1  pop head event; ignored when key_valid=0.
- err_tick  out  1  one-cycle pulse on protocol error or timeout.
- overflow  out  1  sticky: event dropped because FIFO full.
- clr_ovf  in  1  synchronous clear of overflow.

Behaviour:
- Reset (async, active-high): state=IDLE, timeout counter=0, FIFO empty, overflow=0, err_tick=0, key_valid=0, rx_en=1, key_code/key_ext/key_break=0.
- Event word is 10 bits: {ext, brk, code[7:0]}. FIFO is FWFT; outputs are driven from the head entry.
- FSM states: IDLE, GOT_E0, GOT_F0, GOT_E0F0. Transitions are evaluated only on rx_done_tick.
- Discard bytes 0x00 and 0xFF (keyboard error/overrun) in any state: go to IDLE, pulse err_tick, no push.
- IDLE:
  - E0 -> GOT_E0.
  - F0 -> GOT_F0.
  - Any other byte -> push {0,0,byte}, stay in IDLE.
- GOT_E0:
  - F0 -> GOT_E0F0.
  - E0 -> stay in GOT_E0, no error.
  - Other -> push {1,0,byte}, go to IDLE.
- GOT_F0:
  - Other -> push {0,1,byte}, go to IDLE.
  - E0 or F0 -> go to IDLE, pulse err_tick, no push.
- GOT_E0F0:
  - Other -> push {1,1,byte}, go to IDLE.
  - E0 or F0 -> go to IDLE, pulse err_tick, no push.
- Latency: push happens in the rx_done_tick cycle; key_valid rises the next cycle.
- Timeout:
  - Counter is held at 0 in IDLE and cleared on every rx_done_tick.
  - Otherwise it increments each cycle.
  - When it reaches TIMEOUT_CYCLES-1 with no rx_done_tick, go to IDLE and pulse err_tick.
  - rx_done_tick in that same cycle wins: the byte is processed normally and the counter clears.
- FIFO push/pop:
  - Push while full drops the event and sets overflow; FSM state still advances.
  - Pop while empty is ignored.
  - Simultaneous push+pop when full: both succeed, count unchanged.
  - Simultaneous push+pop when empty: push succeeds, pop ignored.
  - Pointers wrap modulo 2^ADDR_W.
- rx_en is combinational ~full. The receiver samples it only at start bit, so a frame already in progress completes regardless.
- overflow and clr_ovf in the same cycle: set wins.
- err_tick and a push never coincide, except that a valid push cannot occur with err by construction.

Decomposition:
- Package ps2_kb_pkg holds:
  - Byte constants: SC_EXT=8'hE0, SC_BRK=8'hF0, SC_ERR0=8'h00, SC_ERR1=8'hFF.
  - FSM state encoding (2 bits).
  - Event width EV_W=10 and field offsets.
- One sub-module: ps2_kb_fifo, a generic FWFT FIFO (data width, ADDR_W) with full/empty/wr/rd. Reusable for the transmit path later.

Test Plan:
- Plain make: byte 1C -> after 1 cycle key_valid=1, code=1C, ext=0, brk=0; key_rd -> key_valid=0.
- Break sequence: F0,1C -> exactly one event {0,1,1C}. Extended break: E0,F0,75 -> one event {1,1,75}.
- Errors: F0,F0 -> err_tick pulse, no event, state IDLE; next byte 29 -> event {0,0,29}. Byte FF after E0 -> err_tick, no event.
- Timeout: E0 then idle TIMEOUT_CYCLES (overridden to 100) -> err_tick at cycle 99, IDLE; next byte 6B -> {0,0,6B}, not extended.
- FIFO full: 4 makes, no reads -> rx_en=0. Force a 5th rx_done_tick -> overflow=1, contents unchanged. Read all 4 in order, then clr_ovf -> overflow=0, rx_en=1.
- Async reset asserted in GOT_E0F0 with 2 events queued -> key_valid=0, rx_en=1. After release, byte 1C -> {0,0,1C}.
